// File: rtl/ctrl_unit_pkg.sv
// Shared constants and types for the WF8 control unit: ALU mode/flag indices,
// opcodes, FSM states and the decoded-instruction record.
package ctrl_unit_pkg;

    localparam int DEFAULT_BIT_COUNT = 8;

    localparam int ALU_MODE_ADD      = 0;
    localparam int ALU_MODE_SH       = 1;
    localparam int ALU_MODE_NOT      = 2;
    localparam int ALU_MODE_AND      = 3;
    localparam int ALU_MODE_OR       = 4;
    localparam int ALU_MODE_XOR      = 5;
    localparam int ALU_MODE_BYPASS_A = 6;
    localparam int ALU_MODE_BYPASS_B = 7;
    localparam int ALU_MODE_COUNT    = 8;

    localparam int BC_FLAG_GT    = 0;
    localparam int BC_FLAG_EQ    = 1;
    localparam int BC_FLAG_COUNT = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_ADDI = 4'h2, OP_SH  = 4'h3,
        OP_SHI  = 4'h4, OP_NOT = 4'h5, OP_AND  = 4'h6, OP_OR  = 4'h7,
        OP_XOR  = 4'h8, OP_MVA = 4'h9, OP_MVR  = 4'hA, OP_LI  = 4'hB,
        OP_BEQ  = 4'hC, OP_BGT = 4'hD, OP_JMP  = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_EXEC, ST_BR, ST_PC_INC, ST_HALT
    } state_e;

    typedef struct packed {
        logic [ALU_MODE_COUNT-1:0] alu_mode;
        logic                      alu_a_sel;
        logic                      alu_b_sel;
        logic                      acc_wr_en;
        logic                      reg_wr_en;
        logic                      is_branch;
        logic                      is_jmp;
        logic                      is_halt;
    } decode_t;

    function automatic logic [ALU_MODE_COUNT-1:0] mode_bit(input int idx);
        return ALU_MODE_COUNT'(1) << idx;
    endfunction

endpackage

// File: rtl/ctrl_unit_insn_decode.sv
// Combinational instruction decode: opcode -> one-hot ALU mode, operand
// selects, write enables and control-flow class for the EXEC state.
module insn_decode
    import ctrl_unit_pkg::*;
(
    input  opcode_e    opcode_i,
    input  logic [2:0] rb_i,
    output decode_t    dec_o
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        dec_o = '0;
        case (opcode_i)
            OP_ADD:  begin dec_o.alu_mode = mode_bit(ALU_MODE_ADD); dec_o.acc_wr_en = 1'b1; end
            OP_ADDI: begin
                dec_o.alu_mode  = mode_bit(ALU_MODE_ADD);
                dec_o.alu_b_sel = 1'b1;
                dec_o.acc_wr_en = 1'b1;
            end
            OP_SH:   begin dec_o.alu_mode = mode_bit(ALU_MODE_SH); dec_o.acc_wr_en = 1'b1; end
            OP_SHI:  begin
                dec_o.alu_mode  = mode_bit(ALU_MODE_SH);
                dec_o.alu_b_sel = 1'b1;
                dec_o.acc_wr_en = 1'b1;
            end
            OP_NOT:  begin dec_o.alu_mode = mode_bit(ALU_MODE_NOT); dec_o.acc_wr_en = 1'b1; end
            OP_AND:  begin dec_o.alu_mode = mode_bit(ALU_MODE_AND); dec_o.acc_wr_en = 1'b1; end
            OP_OR:   begin dec_o.alu_mode = mode_bit(ALU_MODE_OR);  dec_o.acc_wr_en = 1'b1; end
            OP_XOR:  begin dec_o.alu_mode = mode_bit(ALU_MODE_XOR); dec_o.acc_wr_en = 1'b1; end
            OP_MVA:  begin dec_o.alu_mode = mode_bit(ALU_MODE_BYPASS_B); dec_o.acc_wr_en = 1'b1; end
            // x7 is hardwired to zero, so writes to it are dropped here.
            OP_MVR:  begin
                dec_o.alu_mode  = mode_bit(ALU_MODE_BYPASS_A);
                dec_o.reg_wr_en = (rb_i != 3'd7);
            end
            OP_LI:   begin
                dec_o.alu_mode  = mode_bit(ALU_MODE_BYPASS_B);
                dec_o.alu_b_sel = 1'b1;
                dec_o.acc_wr_en = 1'b1;
            end
            OP_BEQ, OP_BGT: dec_o.is_branch = 1'b1;
            OP_JMP:  begin dec_o.alu_mode = mode_bit(ALU_MODE_BYPASS_A); dec_o.is_jmp = 1'b1; end
            OP_HLT:  dec_o.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// WF8 control FSM: fetches over a req/ack handshake, owns pc/ir/branch flags and
// drives the ALU/regfile/accumulator controls combinationally from state and ir.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int BIT_COUNT = DEFAULT_BIT_COUNT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [BIT_COUNT-1:0]      imem_addr,
    input  logic                      imem_ack,
    input  logic [7:0]                imem_data,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      alu_a_sel,
    output logic                      alu_b_sel,
    output logic [BIT_COUNT-1:0]      imm,
    output logic [BIT_COUNT-1:0]      pc,
    input  logic [BIT_COUNT-1:0]      alu_c,
    input  logic [BC_FLAG_COUNT-1:0]  bc_flags,
    output logic [2:0]                reg_rd_idx,
    output logic                      reg_wr_en,
    output logic [2:0]                reg_wr_idx,
    output logic                      acc_wr_en,
    output logic                      halted
);

    state_e                   state_q;
    logic [BIT_COUNT-1:0]     pc_q;
    logic [7:0]               ir_q;
    logic [BC_FLAG_COUNT-1:0] flags_q;
    decode_t                  dec;
    logic                     br_taken;

    insn_decode u_decode (
        .opcode_i (opcode_e'(ir_q[7:4])),
        .rb_i     (ir_q[2:0]),
        .dec_o    (dec)
    );

    assign br_taken = (opcode_e'(ir_q[7:4]) == OP_BEQ) ? flags_q[BC_FLAG_EQ] : flags_q[BC_FLAG_GT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, as real flops do.
            case (state_q)
                ST_IDLE:  state_q <= ST_FETCH;
                ST_FETCH: if (imem_ack) begin
                    ir_q    <= imem_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec.is_halt) begin
                        state_q <= ST_HALT;
                    end else if (dec.is_branch) begin
                        flags_q <= bc_flags;
                        state_q <= ST_BR;
                    end else if (dec.is_jmp) begin
                        pc_q    <= alu_c;
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_PC_INC;
                    end
                end
                ST_BR: begin
                    if (br_taken) begin
                        pc_q    <= alu_c;
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_PC_INC;
                    end
                end
                ST_PC_INC: begin
                    pc_q    <= alu_c;
                    state_q <= ST_FETCH;
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;

    always_comb begin
        imem_req   = 1'b0;
        alu_mode   = '0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        imm        = BIT_COUNT'(ir_q[3:0]);
        reg_rd_idx = 3'd0;
        reg_wr_en  = 1'b0;
        reg_wr_idx = 3'd0;
        acc_wr_en  = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                alu_mode   = dec.alu_mode;
                alu_a_sel  = dec.alu_a_sel;
                alu_b_sel  = dec.alu_b_sel;
                reg_rd_idx = ir_q[2:0];
                reg_wr_en  = dec.reg_wr_en;
                reg_wr_idx = ir_q[2:0];
                acc_wr_en  = dec.acc_wr_en;
            end
            // Taken branches route x6 through the ALU as the new pc.
            ST_BR: if (br_taken) begin
                reg_rd_idx = 3'd6;
                alu_mode   = mode_bit(ALU_MODE_BYPASS_B);
            end
            ST_PC_INC: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 1'b1;
                imm       = BIT_COUNT'(1);
                alu_mode  = mode_bit(ALU_MODE_ADD);
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: behavioural ALU, regfile, accumulator and imem around the
// DUT, checked against an instruction-level reference model.
module tb_ctrl_unit;
    import ctrl_unit_pkg::*;

    localparam int W = DEFAULT_BIT_COUNT;

    logic                      clk;
    logic                      rst_n;
    logic                      imem_req;
    logic [W-1:0]              imem_addr;
    logic                      imem_ack;
    logic [7:0]                imem_data;
    logic [ALU_MODE_COUNT-1:0] alu_mode;
    logic                      alu_a_sel;
    logic                      alu_b_sel;
    logic [W-1:0]              imm;
    logic [W-1:0]              pc;
    logic [W-1:0]              alu_c;
    logic [BC_FLAG_COUNT-1:0]  bc_flags;
    logic [2:0]                reg_rd_idx;
    logic                      reg_wr_en;
    logic [2:0]                reg_wr_idx;
    logic                      acc_wr_en;
    logic                      halted;

    ctrl_unit #(.BIT_COUNT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_mode(alu_mode), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm(imm), .pc(pc),
        .alu_c(alu_c), .bc_flags(bc_flags), .reg_rd_idx(reg_rd_idx), .reg_wr_en(reg_wr_en),
        .reg_wr_idx(reg_wr_idx), .acc_wr_en(acc_wr_en), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath partners: accumulator, regfile (x7 reads 0), ALU.
    logic [7:0] acc;
    logic [7:0] regs   [8];
    logic [7:0] pre_acc;
    logic [7:0] pre_x  [8];
    logic [7:0] rd_val, alu_a, alu_b;

    always_comb begin
        rd_val = (reg_rd_idx == 3'd7) ? 8'h00 : regs[reg_rd_idx];
        alu_a  = alu_a_sel ? pc : acc;
        alu_b  = alu_b_sel ? imm : rd_val;
        alu_c  = 8'h00;
        if      (alu_mode[ALU_MODE_ADD])      alu_c = alu_a + alu_b;
        else if (alu_mode[ALU_MODE_SH])       alu_c = alu_a << alu_b[2:0];
        else if (alu_mode[ALU_MODE_NOT])      alu_c = ~alu_a;
        else if (alu_mode[ALU_MODE_AND])      alu_c = alu_a & alu_b;
        else if (alu_mode[ALU_MODE_OR])       alu_c = alu_a | alu_b;
        else if (alu_mode[ALU_MODE_XOR])      alu_c = alu_a ^ alu_b;
        else if (alu_mode[ALU_MODE_BYPASS_A]) alu_c = alu_a;
        else if (alu_mode[ALU_MODE_BYPASS_B]) alu_c = alu_b;
        bc_flags             = '0;
        bc_flags[BC_FLAG_GT] = (alu_a > alu_b);
        bc_flags[BC_FLAG_EQ] = (alu_a == alu_b);
    end

    // Preload architectural state while reset is held; raw x7 storage is kept so
    // a write that should have been suppressed stays visible.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc <= pre_acc;
            for (int i = 0; i < 8; i++) regs[i] <= pre_x[i];
        end else begin
            if (acc_wr_en) acc <= alu_c;
            if (reg_wr_en) regs[reg_wr_idx] <= alu_c;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] mem [256];
    logic [7:0] f_addr [$];
    int         f_cyc  [$];
    int         base, cyc, ws, wcnt;
    logic       spurious;

    // One cycle: per-cycle invariants, then the imem responder (drives ack at negedge).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            check("mode_onehot0", 32'($onehot0(alu_mode)), 32'd1);
            check("wr_exclusive", 32'(reg_wr_en & acc_wr_en), 32'd0);
            if (halted) check("halt_quiet", 32'({imem_req, reg_wr_en, acc_wr_en}), 32'd0);
        end
        if (rst_n && imem_req) begin
            if (wcnt >= ws) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                f_addr.push_back(imem_addr);
                f_cyc.push_back(cyc);
                wcnt = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack  = spurious;
            imem_data = 8'hF0;
            wcnt      = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'(|{imem_req, imem_addr, alu_mode, alu_a_sel, alu_b_sel, imm, pc,
                                     reg_rd_idx, reg_wr_en, reg_wr_idx, acc_wr_en, halted}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wcnt  = 0;
        base  = f_addr.size();
    endtask

    task automatic wait_fetches(input int n);
        int k = 0;
        while ((f_addr.size() - base) < n && k < 3000) begin
            tick();
            k++;
        end
        check("fetch_timeout", 32'((f_addr.size() - base) >= n), 32'd1);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Instruction-level reference: replays the program from pc 0 and compares the
    // fetch address trace, fetch-to-fetch latency and final acc/regs.
    task automatic run_model(input string name, input int n);
        logic [7:0] m_acc, m_pc, nxt, insn, xv, imm4;
        logic [7:0] m_x [8];
        int lat;
        m_acc = pre_acc;
        m_x   = pre_x;
        m_pc  = 8'h00;
        for (int k = 0; k < n; k++) begin
            check({name, "_addr"}, 32'(f_addr[base+k]), 32'(m_pc));
            insn = mem[m_pc];
            xv   = (insn[2:0] == 3'd7) ? 8'h00 : m_x[insn[2:0]];
            imm4 = {4'h0, insn[3:0]};
            nxt  = m_pc + 8'd1;
            lat  = 3;
            case (insn[7:4])
                4'h1: m_acc = m_acc + xv;
                4'h2: m_acc = m_acc + imm4;
                4'h3: m_acc = m_acc << (xv % 8);
                4'h4: m_acc = m_acc << (imm4 % 8);
                4'h5: m_acc = ~m_acc;
                4'h6: m_acc = m_acc & xv;
                4'h7: m_acc = m_acc | xv;
                4'h8: m_acc = m_acc ^ xv;
                4'h9: m_acc = xv;
                4'hA: if (insn[2:0] != 3'd7) m_x[insn[2:0]] = m_acc;
                4'hB: m_acc = imm4;
                4'hC: if (m_acc == xv) nxt = m_x[6]; else lat = 4;
                4'hD: if (m_acc > xv)  nxt = m_x[6]; else lat = 4;
                4'hE: begin nxt = m_acc; lat = 0; end
                4'hF: lat = 0;
                default: ;
            endcase
            if (lat > 0)
                check({name, "_lat"}, 32'(f_cyc[base+k+1] - f_cyc[base+k]), 32'(lat + ws));
            m_pc = nxt;
        end
        check({name, "_next_addr"}, 32'(f_addr[base+n]), 32'(m_pc));
        check({name, "_acc"}, 32'(acc), 32'(m_acc));
        for (int i = 0; i < 8; i++) check({name, "_reg"}, 32'(regs[i]), 32'(m_x[i]));
    endtask

    typedef struct {
        string      name;
        logic [7:0] insn;
        logic [7:0] acc0;
        logic [7:0] xr;
        logic [7:0] exp_acc;
        logic [7:0] exp_pc;
        logic [7:0] exp_xr;
        int         exp_lat;
    } vec_t;

    vec_t vecs [$];

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        spurious  = 1'b0;
        ws        = 0;
        wcnt      = 0;
        cyc       = 0;
        base      = 0;
        pre_acc   = 8'h00;
        for (int i = 0; i < 8; i++) pre_x[i] = 8'h00;

        // Single instruction at 0; x6 = 0x20 is the branch target; xr lives in x[rb].
        vecs.push_back('{"add",     8'h11, 8'h05, 8'h03, 8'h08, 8'h01, 8'h03, 3});
        vecs.push_back('{"addi",    8'h27, 8'h05, 8'h00, 8'h0C, 8'h01, 8'h00, 3});
        vecs.push_back('{"sh",      8'h31, 8'h03, 8'h02, 8'h0C, 8'h01, 8'h02, 3});
        vecs.push_back('{"shi",     8'h41, 8'h81, 8'h00, 8'h02, 8'h01, 8'h00, 3});
        vecs.push_back('{"not",     8'h50, 8'h0F, 8'h00, 8'hF0, 8'h01, 8'h00, 3});
        vecs.push_back('{"and",     8'h61, 8'h3C, 8'h0F, 8'h0C, 8'h01, 8'h0F, 3});
        vecs.push_back('{"or",      8'h71, 8'h30, 8'h03, 8'h33, 8'h01, 8'h03, 3});
        vecs.push_back('{"xor",     8'h81, 8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h0F, 3});
        vecs.push_back('{"mva",     8'h91, 8'h00, 8'h55, 8'h55, 8'h01, 8'h55, 3});
        vecs.push_back('{"mvr",     8'hA1, 8'h42, 8'h00, 8'h42, 8'h01, 8'h42, 3});
        vecs.push_back('{"mvr_x7",  8'hA7, 8'h42, 8'h99, 8'h42, 8'h01, 8'h99, 3});
        vecs.push_back('{"mva_x7",  8'h97, 8'h33, 8'h99, 8'h00, 8'h01, 8'h99, 3});
        vecs.push_back('{"li",      8'hB9, 8'h00, 8'h00, 8'h09, 8'h01, 8'h00, 3});
        vecs.push_back('{"nop",     8'h00, 8'h12, 8'h00, 8'h12, 8'h01, 8'h00, 3});
        vecs.push_back('{"beq_t",   8'hC1, 8'h07, 8'h07, 8'h07, 8'h20, 8'h07, 3});
        vecs.push_back('{"beq_nt",  8'hC1, 8'h07, 8'h06, 8'h07, 8'h01, 8'h06, 4});
        vecs.push_back('{"bgt_t",   8'hD1, 8'h09, 8'h04, 8'h09, 8'h20, 8'h04, 3});
        vecs.push_back('{"bgt_lt",  8'hD1, 8'h04, 8'h09, 8'h04, 8'h01, 8'h09, 4});
        vecs.push_back('{"bgt_eq",  8'hD1, 8'h05, 8'h05, 8'h05, 8'h01, 8'h05, 4});

        foreach (vecs[i]) begin
            fill_mem(8'hF0);
            mem[0]  = vecs[i].insn;
            pre_acc = vecs[i].acc0;
            for (int r = 0; r < 8; r++) pre_x[r] = 8'h00;
            pre_x[6]                 = 8'h20;
            pre_x[vecs[i].insn[2:0]] = vecs[i].xr;
            ws = 0;
            do_reset();
            wait_fetches(2);
            check({vecs[i].name, "_pc"},  32'(f_addr[base+1]), 32'(vecs[i].exp_pc));
            check({vecs[i].name, "_lat"}, 32'(f_cyc[base+1] - f_cyc[base]), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_acc"}, 32'(acc), 32'(vecs[i].exp_acc));
            check({vecs[i].name, "_xr"},  32'(regs[vecs[i].insn[2:0]]), 32'(vecs[i].exp_xr));
        end

        // LI 5; ADDI 3; MVR x2 with zero and two wait states.
        for (int w = 0; w <= 2; w += 2) begin
            fill_mem(8'hF0);
            mem[0] = 8'hB5; mem[1] = 8'h23; mem[2] = 8'hA2;
            pre_acc = 8'h00;
            for (int r = 0; r < 8; r++) pre_x[r] = 8'h00;
            ws = w;
            do_reset();
            wait_fetches(4);
            run_model("prog1", 3);
            check("prog1_acc8", 32'(acc), 32'h08);
            check("prog1_x2",   32'(regs[2]), 32'h08);
            check("prog1_pc3",  32'(f_addr[base+3]), 32'h03);
        end

        // pc wrap 0xFF -> 0x00 via JMP then NOP.
        fill_mem(8'hF0);
        mem[0] = 8'hE0; mem[8'hFF] = 8'h00;
        pre_acc = 8'hFF;
        ws = 0;
        do_reset();
        wait_fetches(3);
        check("jmp_ff",  32'(f_addr[base+1]), 32'hFF);
        check("pc_wrap", 32'(f_addr[base+2]), 32'h00);

        // JMP to 0x10.
        fill_mem(8'hF0);
        mem[0] = 8'hE0;
        pre_acc = 8'h10;
        do_reset();
        wait_fetches(2);
        check("jmp_10", 32'(f_addr[base+1]), 32'h10);

        // Acks outside FETCH (carrying an HLT byte) must be ignored.
        fill_mem(8'h00);
        do_reset();
        spurious = 1'b1;
        wait_fetches(5);
        spurious = 1'b0;
        check("spurious_addr", 32'(f_addr[base+4]), 32'h04);
        check("spurious_halt", 32'(halted), 32'd0);

        // HLT is absorbing: no requests for 20 cycles, pc frozen.
        fill_mem(8'hF0);
        pre_acc = 8'h5A;
        do_reset();
        wait_fetches(1);
        repeat (3) tick();
        check("halted", 32'(halted), 32'd1);
        begin
            logic seen = 1'b0;
            repeat (20) begin
                tick();
                seen = seen | imem_req;
            end
            check("halt_no_req", 32'(seen), 32'd0);
        end
        check("halt_pc",  32'(pc), 32'h00);
        check("halt_acc", 32'(acc), 32'h5A);

        // Asynchronous reset in the middle of a wait-stated fetch.
        fill_mem(8'h00);
        ws = 3;
        do_reset();
        begin
            int k = 0;
            while (!(imem_req && imem_addr == 8'h03) && k < 200) begin
                tick();
                k++;
            end
            check("mid_fetch_reached", 32'(imem_req && imem_addr == 8'h03), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_drop", 32'(imem_req), 32'd0);
        check("rst_pc_zero",  32'(pc), 32'h00);
        tick();
        tick();
        rst_n = 1'b1;
        wcnt  = 0;
        base  = f_addr.size();
        wait_fetches(1);
        check("refetch_0", 32'(f_addr[base]), 32'h00);

        // Randomized programs (no HLT) against the reference model.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
            pre_acc = 8'($urandom);
            for (int i = 0; i < 8; i++) pre_x[i] = 8'($urandom);
            ws = $urandom_range(0, 2);
            do_reset();
            wait_fetches(41);
            run_model("rand", 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
